// File: rtl/prim_pad_attr_seq.sv
// rtl/prim_pad_attr_seq.sv - multi-pad attribute register bank with WARL masking and break-before-make updates
module prim_pad_attr_seq #(
    parameter int unsigned NumPads      = 4,
    parameter int unsigned AttrDw       = 8,
    parameter int unsigned PadType      = 0,
    parameter int unsigned SettleCycles = 3,
    parameter logic [AttrDw-1:0] ResetAttr = '0,
    parameter logic [AttrDw-1:0] SafeAttr  = '0,
    localparam int unsigned AW = (NumPads > 1) ? $clog2(NumPads) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [AW-1:0]             addr_i,
    input  logic [AttrDw-1:0]         wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [AttrDw-1:0]         rdata_o,
    output logic                      err_o,
    output logic                      busy_o,
    output logic [NumPads*AttrDw-1:0] attr_o,
    output logic [AttrDw-1:0]         warl_mask_o
);

    // Generic pads only implement the two low attribute bits; full pads implement all of them.
    localparam logic [AttrDw-1:0] Mask = (PadType == 1) ? AttrDw'(2'b11) : {AttrDw{1'b1}};
    localparam logic [AttrDw-1:0] ResetM = ResetAttr & Mask;
    localparam logic [AttrDw-1:0] SafeM  = SafeAttr & Mask;

    // Counter is sized for the settle length; kept at least one bit wide so S=0 still elaborates.
    localparam int unsigned CW    = (SettleCycles > 0) ? $clog2(SettleCycles + 1) : 1;
    localparam int unsigned SLoad = (SettleCycles > 0) ? SettleCycles - 1 : 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SAFE  = 2'd1,
        APPLY = 2'd2
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic [CW-1:0]       cnt_q;
    logic [AW-1:0]       idx_q;
    logic [AttrDw-1:0]   val_q;
    logic [AttrDw-1:0]   attr_q [NumPads];

    logic                addr_ok;
    logic                gnt;
    logic                acc_err;
    logic                acc_rd;
    logic                acc_wr;

    // Out-of-range pad indices are possible when NumPads is not a power of two.
    assign addr_ok = ({1'b0, addr_i} < (AW + 1)'(NumPads));

    // Next-state and access decode; accesses are only taken while idle.
    always_comb begin
        state_d = state_q;
        gnt     = 1'b0;
        acc_err = 1'b0;
        acc_rd  = 1'b0;
        acc_wr  = 1'b0;
        case (state_q)
            IDLE: begin
                gnt = req_i;
                if (req_i) begin
                    if (!addr_ok) begin
                        acc_err = 1'b1;
                    end else if (!we_i) begin
                        acc_rd = 1'b1;
                    end else begin
                        acc_wr = 1'b1;
                        if (SettleCycles > 0) begin
                            state_d = SAFE;
                        end else begin
                            state_d = APPLY;
                        end
                    end
                end
            end
            SAFE: begin
                if (cnt_q == '0) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Attribute storage, settle counter and single-cycle response generation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumPads); i++) begin
                attr_q[i] <= ResetM;
            end
            cnt_q    <= '0;
            idx_q    <= '0;
            val_q    <= '0;
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
            if (acc_err) begin
                rvalid_o <= 1'b1;
                err_o    <= 1'b1;
            end else if (acc_rd) begin
                rvalid_o <= 1'b1;
                rdata_o  <= attr_q[addr_i];
            end else if (acc_wr) begin
                idx_q <= addr_i;
                val_q <= wdata_i & Mask;
                if (SettleCycles > 0) begin
                    attr_q[addr_i] <= SafeM;
                    cnt_q          <= CW'(SLoad);
                end else begin
                    attr_q[addr_i] <= wdata_i & Mask;
                    rvalid_o       <= 1'b1;
                end
            end
            if (state_q == SAFE) begin
                if (cnt_q == '0) begin
                    attr_q[idx_q] <= val_q;
                    rvalid_o      <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NumPads); g++) begin : g_attr
        assign attr_o[g*AttrDw +: AttrDw] = attr_q[g];
    end

    assign gnt_o       = gnt;
    assign busy_o      = (state_q != IDLE);
    assign warl_mask_o = Mask;

endmodule

// File: doc/prim_pad_attr_seq.md
Name: prim_pad_attr_seq

Overview:
Parametrised, multi-pad successor to the single-pad attribute primitive. It holds one attribute register per pad and constrains every write to the attributes the selected pad type supports (WARL mask from PadType). Each attribute change uses a break-before-make sequence: the pad is driven to a safe attribute for SettleCycles cycles, then the new value is applied. It sits between the pinmux/padring CSR logic and the pad attribute inputs of the pad wrappers.

Parameters:
- NumPads, 4: number of pads/channels. Must be ≥1.
- AttrDw, 8: attribute width per pad. Must be ≥2.
- PadType, 0: 0 = full pad, mask all-ones. 1 = generic pad, mask = AttrDw'(2'b11).
- SettleCycles, 3: cycles the safe attribute is held before apply. 0 is legal.
- ResetAttr, '0: per-pad reset attribute. Masked before use.
- SafeAttr, '0: attribute driven during settle. Masked before use.
- Derived: AW = max(1, $clog2(NumPads)); Mask as defined by PadType.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- req_i  in  1  access request.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  AW  pad index.
- wdata_i  in  AttrDw  write attribute.
- gnt_o  out  1  request accepted this cycle (combinational).
- rvalid_o  out  1  response pulse (read data or write completion).
- rdata_o  out  AttrDw  read data. 0 on write or error responses.
- err_o  out  1  response error, qualified by rvalid_o.
- busy_o  out  1  sequencer not IDLE.
- attr_o  out  NumPads*AttrDw  per-pad attribute; pad i occupies bits [i*AttrDw +: AttrDw].
- warl_mask_o  out  AttrDw  constant supported-attribute mask.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: every pad attr = ResetAttr & Mask. rvalid_o=0, err_o=0, rdata_o=0, busy_o=0. State IDLE, counter 0.
- Reset mid-sequence: the pending write is dropped and the pad returns to its reset value. No response is issued.
- FSM states: IDLE, SAFE, APPLY.
- gnt_o = req_i && state==IDLE. No accepts outside IDLE; the requester holds req_i until granted.
- Read accepted at T, valid addr (addr_i < NumPads):
  - T+1: rvalid_o=1, rdata_o=attr[addr], err_o=0.
  - State stays IDLE, so back-to-back reads are allowed.
- Any access accepted at T with addr_i ≥ NumPads:
  - T+1: rvalid_o=1, err_o=1, rdata_o=0.
  - No state change, no attr change.
- Valid write accepted at T:
  - Capture idx=addr_i and val=wdata_i & Mask.
  - SettleCycles>0: IDLE→SAFE. attr[idx]=SafeAttr&Mask visible from T+1. Counter loads SettleCycles-1 and decrements in SAFE. Exit SAFE when counter==0 (SAFE spans T+1..T+S).
  - Either case, at T+S+1: state APPLY, attr[idx]=val visible, rvalid_o=1, err_o=0, rdata_o=0.
  - T+S+2: state IDLE, next grant possible.
  - SettleCycles==0: no SAFE state; IDLE→APPLY directly and val is visible at T+1.
- Write of the value already stored: the full safe/apply sequence still runs (no shortcut).
- Unselected pads never change during a sequence.
- busy_o = (state != IDLE).
- rvalid_o is a single-cycle pulse, never asserted two cycles in a row for one access.
- Counter width is $clog2(SettleCycles+1); it cannot wrap because it is only loaded in IDLE.
- Unmasked bits of attr_o are always 0.

Test Plan:
- Reset: NumPads=4, AttrDw=8, PadType=0, ResetAttr=8'h5A, SafeAttr=8'h10, S=3; assert rst_i 2 cycles → attr_o=32'h5A5A5A5A, busy_o=0, rvalid_o=0.
- Write pad2 ← 8'hC3 at T → gnt_o=1 at T; attr[2]=8'h10 at T+1..T+3; attr[2]=8'hC3 with rvalid_o=1 at T+4; busy_o=0 at T+5; pads 0, 1, 3 remain 8'h5A throughout.
- PadType=1: write pad0 ← 8'hFF then read pad0 → rdata_o=8'h03; warl_mask_o=8'h03; safe phase shows 8'h00.
- Request during busy: second write issued at T+1 → gnt_o=0 until T+5, granted at T+5, completes with rvalid_o at T+9.
- addr_i=3'd5 with NumPads=5 (AW=3), read and write → err_o=1 with rvalid_o at T+1, attr_o unchanged, busy_o stays 0.
- SettleCycles=0: write pad1 ← 8'h7E at T → attr[1]=8'h7E with rvalid_o at T+1; rst_i asserted at T+2 of an S=3 sequence → pad restored to ResetAttr, no rvalid_o.
